// File: rtl/seg_scroll_display.sv
// Scrolling multi-digit 7-segment message display.
// A MSG_LEN-entry hex message is written through the load port and scrolled
// across N_DIGITS time-multiplexed digits, left or right, with run/pause.
module seg_scroll_display #(
   parameter int DIV      = 25_000_000,
   parameter int SCAN_DIV = 50_000,
   parameter int MSG_LEN  = 8,
   parameter int N_DIGITS = 4,
   parameter int AW       = $clog2(MSG_LEN)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                dir,
   input  logic                load_we,
   input  logic [AW-1:0]       load_addr,
   input  logic [3:0]          load_data,
   output logic [6:0]          seg,
   output logic [N_DIGITS-1:0] sel,
   output logic [AW-1:0]       pos,
   output logic                wrap
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int EW = AW + SW + 1;
   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] IDX_LAST  = SW'(N_DIGITS - 1);
   localparam logic [AW-1:0] POS_LAST  = AW'(MSG_LEN - 1);
   localparam logic [AW:0]   MSG_LEN_W = (AW + 1)'(MSG_LEN);
   localparam logic [EW-1:0] MSG_LEN_E = EW'(MSG_LEN);
   // Enough subtract passes to fold pos + scan_idx back into 0..MSG_LEN-1
   localparam int unsigned   N_SUB     = N_DIGITS / MSG_LEN + 1;

   logic [DW-1:0]       div_cnt_q, div_cnt_d;
   logic [CW-1:0]       scan_cnt_q, scan_cnt_d;
   logic [SW-1:0]       scan_idx_q, scan_idx_d;
   logic [AW-1:0]       pos_q, pos_d;
   logic                wrap_q, wrap_d;
   logic [6:0]          seg_q, seg_d;
   logic [N_DIGITS-1:0] sel_q, sel_d;
   logic [3:0]          mem_q [MSG_LEN];
   logic                tick;
   logic                step;
   logic [EW-1:0]       sum_e;
   logic [AW-1:0]       entry;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0:    hex7 = 7'h7E;
         4'h1:    hex7 = 7'h30;
         4'h2:    hex7 = 7'h6D;
         4'h3:    hex7 = 7'h79;
         4'h4:    hex7 = 7'h33;
         4'h5:    hex7 = 7'h5B;
         4'h6:    hex7 = 7'h5F;
         4'h7:    hex7 = 7'h70;
         4'h8:    hex7 = 7'h7F;
         4'h9:    hex7 = 7'h7B;
         4'hA:    hex7 = 7'h77;
         4'hB:    hex7 = 7'h1F;
         4'hC:    hex7 = 7'h4E;
         4'hD:    hex7 = 7'h3D;
         4'hE:    hex7 = 7'h4F;
         default: hex7 = 7'h47;
      endcase
   endfunction

   assign tick = (div_cnt_q == DIV_LAST);
   assign step = tick & en;

   // Next state of the step divider, scan counters, scroll position and wrap flag
   always_comb begin
      div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
      scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
      scan_idx_d = scan_idx_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
      end
      pos_d = pos_q;
      if (step) begin
         if (dir) begin
            pos_d = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
         end else begin
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
         end
      end
      wrap_d = step && (pos_d == '0);
   end

   // Message entry for the digit being scanned, reduced modulo MSG_LEN by compare
   always_comb begin
      sum_e = EW'(pos_q) + EW'(scan_idx_q);
      for (int unsigned i = 0; i < N_SUB; i++) begin
         if (sum_e >= MSG_LEN_E) begin
            sum_e = sum_e - MSG_LEN_E;
         end
      end
      entry = sum_e[AW-1:0];
      seg_d = hex7(mem_q[entry]);
      sel_d = '1;
      sel_d[scan_idx_q] = 1'b0;
   end

   // Timing, position and display registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q  <= '0;
         scan_cnt_q <= '0;
         scan_idx_q <= '0;
         pos_q      <= '0;
         wrap_q     <= 1'b0;
         seg_q      <= '0;
         sel_q      <= '1;
      end else begin
         div_cnt_q  <= div_cnt_d;
         scan_cnt_q <= scan_cnt_d;
         scan_idx_q <= scan_idx_d;
         pos_q      <= pos_d;
         wrap_q     <= wrap_d;
         seg_q      <= seg_d;
         sel_q      <= sel_d;
      end
   end

   // Message memory: cleared on reset, out-of-range addresses ignored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < MSG_LEN; i++) begin
            mem_q[i] <= '0;
         end
      end else if (load_we && ({1'b0, load_addr} < MSG_LEN_W)) begin
         mem_q[load_addr] <= load_data;
      end
   end

   assign seg  = seg_q;
   assign sel  = sel_q;
   assign pos  = pos_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_seg_scroll_display.sv
// Directed bench for seg_scroll_display: a 4-digit / 8-entry instance for the
// scroll behaviour and an 8-digit / 6-entry instance for ring wrap and
// out-of-range load addresses.
module tb_seg_scroll_display;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       dir = 1'b0;
   logic       load_we = 1'b0;
   logic [2:0] load_addr = '0;
   logic [3:0] load_data = '0;
   logic [6:0] seg;
   logic [3:0] sel;
   logic [2:0] pos;
   logic       wrap;

   logic       en2 = 1'b0;
   logic [3:0] load_data2 = '0;
   logic [6:0] seg2;
   logic [7:0] sel2;
   logic [2:0] pos2;
   logic       wrap2;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] msg [8] = '{4'h1, 4'h9, 4'h0, 4'h3, 4'h0, 4'h4, 4'h1, 4'h9};
   logic [6:0] exp2 [8] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h7E, 7'h30};

   seg_scroll_display #(.DIV(4), .SCAN_DIV(2), .MSG_LEN(8), .N_DIGITS(4)) u_dut (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load_we(load_we),
      .load_addr(load_addr), .load_data(load_data),
      .seg(seg), .sel(sel), .pos(pos), .wrap(wrap)
   );

   seg_scroll_display #(.DIV(4), .SCAN_DIV(1), .MSG_LEN(6), .N_DIGITS(8)) u_oor (
      .clk(clk), .rst(rst), .en(en2), .dir(dir), .load_we(load_we),
      .load_addr(load_addr), .load_data(load_data2),
      .seg(seg2), .sel(sel2), .pos(pos2), .wrap(wrap2)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_pos(input logic [2:0] p, input int bound, input string tag);
      for (int i = 0; i < bound; i++) begin
         step(1);
         if (pos === p) break;
      end
      chk(tag, 32'(pos), 32'(p));
   endtask

   task automatic wait_digit(input int d, input logic [6:0] exp, input string tag);
      logic [3:0] want;
      want = ~(4'b0001 << d);
      for (int i = 0; i < 16; i++) begin
         step(1);
         if (sel === want) break;
      end
      chk({tag, "_sel"}, 32'(sel), 32'(want));
      chk(tag, 32'(seg), 32'(exp));
   endtask

   task automatic wait_digit2(input int d, input logic [6:0] exp, input string tag);
      logic [7:0] want;
      want = ~(8'b0000_0001 << d);
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (sel2 === want) break;
      end
      chk({tag, "_sel"}, 32'(sel2), 32'(want));
      chk(tag, 32'(seg2), 32'(exp));
   endtask

   initial begin
      // Reset state
      #1 rst = 1'b1;
      #2;
      chk("rst_pos", 32'(pos), 32'd0);
      chk("rst_seg", 32'(seg), 32'h00);
      chk("rst_sel", 32'(sel), 32'hF);
      chk("rst_wrap", 32'(wrap), 32'd0);
      chk("rst_sel2", 32'(sel2), 32'hFF);
      step(2);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1);
         if (sel === 4'b1110) break;
      end
      chk("first_sel", 32'(sel), 32'hE);

      // Load message; second instance gets 0..5 plus writes to addresses 6,7
      for (int a = 0; a < 8; a++) begin
         load_addr  = 3'(a);
         load_data  = msg[a];
         load_data2 = (a < 6) ? 4'(a) : 4'hF;
         load_we    = 1'b1;
         step(1);
      end
      load_we = 1'b0;
      chk("pos_frozen_load", 32'(pos), 32'd0);
      wait_digit(0, 7'h30, "ld_dig0");
      wait_digit(1, 7'h7B, "ld_dig1");
      wait_digit(2, 7'h7E, "ld_dig2");
      wait_digit(3, 7'h79, "ld_dig3");
      for (int d = 0; d < 8; d++) begin
         wait_digit2(d, exp2[d], $sformatf("oor_dig%0d", d));
      end
      chk("oor_pos", 32'(pos2), 32'd0);

      // Scroll left
      en = 1'b1;
      wait_pos(3'd1, 6, "left_pos1");
      chk("left_wrap1", 32'(wrap), 32'd0);
      en = 1'b0;
      wait_digit(0, 7'h7B, "dig0_pos1");
      chk("pos_paused", 32'(pos), 32'd1);
      en = 1'b1;
      wait_pos(3'd2, 6, "left_pos2");
      step(3);
      chk("left_hold2", 32'(pos), 32'd2);
      step(1);
      chk("left_pos3", 32'(pos), 32'd3);
      chk("left_wrap3", 32'(wrap), 32'd0);
      for (int p = 4; p < 8; p++) begin
         step(4);
         chk($sformatf("left_pos%0d", p), 32'(pos), 32'(p));
      end
      step(4);
      chk("left_pos0", 32'(pos), 32'd0);
      chk("left_wrap_hi", 32'(wrap), 32'd1);
      en = 1'b0;
      step(1);
      chk("left_wrap_lo", 32'(wrap), 32'd0);
      chk("left_pos0_hold", 32'(pos), 32'd0);

      // Live write to a displayed entry
      load_addr = 3'd2;
      load_data = 4'hF;
      load_we   = 1'b1;
      step(1);
      load_we = 1'b0;
      wait_digit(2, 7'h47, "wr_dig2");
      wait_digit(3, 7'h79, "wr_dig3");

      // Scroll right from 0
      dir = 1'b1;
      en  = 1'b1;
      wait_pos(3'd7, 6, "right_pos7");
      chk("right_wrap7", 32'(wrap), 32'd0);
      step(4);
      chk("right_pos6", 32'(pos), 32'd6);
      chk("right_wrap6", 32'(wrap), 32'd0);
      step(4);
      chk("right_pos5", 32'(pos), 32'd5);

      // Reset mid-run with a write pending
      load_addr = 3'd5;
      load_data = 4'hA;
      load_we   = 1'b1;
      rst       = 1'b1;
      #1;
      chk("mid_rst_pos", 32'(pos), 32'd0);
      chk("mid_rst_seg", 32'(seg), 32'h00);
      chk("mid_rst_sel", 32'(sel), 32'hF);
      chk("mid_rst_wrap", 32'(wrap), 32'd0);
      step(1);
      load_we = 1'b0;
      dir     = 1'b0;
      rst     = 1'b0;
      step(3);
      chk("rel_pos_hold", 32'(pos), 32'd0);
      step(1);
      chk("rel_first_tick", 32'(pos), 32'd1);
      for (int d = 0; d < 4; d++) begin
         wait_digit(d, 7'h7E, $sformatf("clr_dig%0d", d));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
